// File: rtl/debounced_gate_array_if.sv
// Pin/LED bundle for debounced_gate_array: raw inputs and controls in, registered LED state out.
interface debounced_gate_array_if #(
  parameter int N_IN    = 2,
  parameter int COUNT_W = 8
);
  logic [N_IN-1:0]    pmod;
  logic [1:0]         mode;
  logic               toggle_en;
  logic [N_IN:0]      led;
  logic [N_IN-1:0]    press;
  logic [COUNT_W-1:0] result_cnt;

  modport master (output pmod, mode, toggle_en, input led, press, result_cnt);
  modport slave  (input pmod, mode, toggle_en, output led, press, result_cnt);
endinterface

// File: rtl/debounced_gate_array.sv
// N-channel synchronise/debounce/optional-toggle front end feeding a selectable
// AND/OR/XOR/NAND reduction with registered LEDs and a result rising-edge counter.
module debounced_gate_array #(
  parameter int N_IN            = 2,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int COUNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  debounced_gate_array_if.slave bus
);
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {MODE_AND, MODE_OR, MODE_XOR, MODE_NAND} mode_e;

  logic [N_IN-1:0]    sync1_q, sync2_q;
  logic [N_IN-1:0]    act;
  logic [CNT_W-1:0]   db_cnt_q [N_IN];
  logic [CNT_W-1:0]   db_cnt_d [N_IN];
  logic [N_IN-1:0]    stable_q, stable_d;
  logic [N_IN-1:0]    press_q, press_d;
  logic [N_IN-1:0]    tog_q, tog_d;
  logic [N_IN-1:0]    op;
  logic               gate;
  logic [N_IN:0]      led_q, led_d;
  logic [COUNT_W-1:0] result_cnt_q, result_cnt_d;

  assign act = sync2_q ^ {N_IN{ACTIVE_LOW}};

  // A disagreeing run must last DEBOUNCE_CYCLES edges; any agreeing edge restarts it.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    stable_d = stable_q;
    for (int i = 0; i < N_IN; i++) begin
      db_cnt_d[i] = '0;
      if (act[i] != stable_q[i]) begin
        if (db_cnt_q[i] == CNT_LAST) stable_d[i] = act[i];
        else                         db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press_d = stable_d & ~stable_q;
  assign tog_d   = bus.toggle_en ? (tog_q ^ press_q) : '0;
  assign op      = bus.toggle_en ? tog_q : stable_q;

  always_comb begin
    gate = 1'b0;
    unique case (mode_e'(bus.mode))
      MODE_AND:  gate = &op;
      MODE_OR:   gate = |op;
      MODE_XOR:  gate = ^op;
      MODE_NAND: gate = ~&op;
      default:   gate = 1'b0;
    endcase
  end

  assign led_d        = {gate, op};
  assign result_cnt_d = (!led_q[N_IN] && gate) ? result_cnt_q + COUNT_W'(1) : result_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= {N_IN{ACTIVE_LOW}};
      sync2_q      <= {N_IN{ACTIVE_LOW}};
      stable_q     <= '0;
      press_q      <= '0;
      tog_q        <= '0;
      led_q        <= '0;
      result_cnt_q <= '0;
      // NOTE: the counter array is flop-based and must reset so a pending transition is dropped.
      for (int i = 0; i < N_IN; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q      <= bus.pmod;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      press_q      <= press_d;
      tog_q        <= tog_d;
      led_q        <= led_d;
      result_cnt_q <= result_cnt_d;
      for (int i = 0; i < N_IN; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign bus.led        = led_q;
  assign bus.press      = press_q;
  assign bus.result_cnt = result_cnt_q;
endmodule
